bmp_plot_reader: RTL and testbench

Streaming decoder for uncompressed 24-bit BMP files: accepts the file as a byte stream over a valid/ready handshake, parses and validates the 54-byte header, then converts each BGR pixel to a 3-bit colour and drives the `x`/`y`/`color`/`plot` pixel-write interface of the VGA path. It is the reading end of the framebuffer/BMP dump path. A captured `vga.bmp`, or any conforming image of at most MAX_W×MAX_H, can be replayed onto the screen or into the simulation framebuffer.

---
 rtl/bmp_plot_reader.sv | 160 ++++++++++++++++
 tb/tb_bmp_plot_reader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmp_plot_reader.sv
// Streaming 24-bit BMP decoder: parses the 54-byte header, then plots each BGR pixel as a 3-bit colour.
// Optional build macro BMP_PLOT_TRANSPARENT_EN suppresses the plot strobe for black pixels.
module bmp_plot_reader #(
    parameter int MAX_W = 336,
    parameter int MAX_H = 210
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic [2:0] color,
    output logic       plot,
    output logic       done,
    output logic       error
);

    typedef enum logic [2:0] {S_HEADER, S_PIXEL, S_PAD, S_DONE, S_ERROR} state_t;

    state_t      state_q, state_d;
    logic        rdy_q;
    logic [5:0]  hcnt;
    logic [1:0]  comp;
    logic [1:0]  pcnt;
    logic [9:0]  col;
    logic [8:0]  row;
    logic [15:0] sig, planes, bpp;
    logic [31:0] off, w, h;
    logic        b7, g7;
    logic        acc, hdr_ok, last_col, last_row;
    logic [1:0]  pad;
    logic [2:0]  pix_color;

    function automatic logic [2:0] bgr_to_rgb3(input logic r, input logic g, input logic b);
        return {r, g, b};
    endfunction

    assign acc       = in_valid && rdy_q;
    // (4 - 3W mod 4) mod 4 reduces to W mod 4
    assign pad       = w[1:0];
    assign last_col  = (col == w[9:0] - 10'd1);
    assign last_row  = (row == h[8:0] - 9'd1);
    assign pix_color = bgr_to_rgb3(in_data[7], g7, b7);
    assign hdr_ok    = (sig == 16'h4D42) && (off == 32'd54) && (planes == 16'd1) &&
                       (bpp == 16'd24) && (w != 32'd0) && (w <= 32'(MAX_W)) &&
                       (h != 32'd0) && (h <= 32'(MAX_H));

    assign in_ready = rdy_q;
    assign done     = (state_q == S_DONE);
    assign error    = (state_q == S_ERROR);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HEADER: if (acc && hcnt == 6'd53) state_d = hdr_ok ? S_PIXEL : S_ERROR;
            S_PIXEL: begin
                if (acc && comp == 2'd2 && last_col) begin
                    if (pad != 2'd0)   state_d = S_PAD;
                    else if (last_row) state_d = S_DONE;
                end
            end
            S_PAD:   if (acc && pcnt == pad - 2'd1 && last_row) state_d = S_DONE;
                     else if (acc && pcnt == pad - 2'd1) state_d = S_PIXEL;
            S_DONE, S_ERROR: if (start) state_d = S_HEADER;
            default: state_d = S_HEADER;
        endcase
    end

    // Control and registered plot outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_HEADER;
            rdy_q   <= 1'b0;
            hcnt    <= '0;
            comp    <= '0;
            pcnt    <= '0;
            col     <= '0;
            row     <= '0;
            plot    <= 1'b0;
            x       <= '0;
            y       <= '0;
            color   <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d == S_HEADER) || (state_d == S_PIXEL) || (state_d == S_PAD);
            plot    <= 1'b0;
            if (acc) begin
                case (state_q)
                    S_HEADER: begin
                        hcnt <= (hcnt == 6'd53) ? 6'd0 : hcnt + 6'd1;
                        comp <= '0;
                        pcnt <= '0;
                        col  <= '0;
                        row  <= '0;
                    end
                    S_PIXEL: begin
                        if (comp == 2'd2) begin
                            comp  <= '0;
`ifdef BMP_PLOT_TRANSPARENT_EN
                            plot  <= (pix_color != 3'b000);
`else
                            plot  <= 1'b1;
`endif
                            x     <= col;
                            y     <= h[8:0] - 9'd1 - row;
                            color <= pix_color;
                            if (last_col) begin
                                col <= '0;
                                if (pad == 2'd0 && !last_row) row <= row + 9'd1;
                            end else begin
                                col <= col + 10'd1;
                            end
                        end else begin
                            comp <= comp + 2'd1;
                        end
                    end
                    S_PAD: begin
                        if (pcnt == pad - 2'd1) begin
                            pcnt <= '0;
                            if (!last_row) row <= row + 9'd1;
                        end else begin
                            pcnt <= pcnt + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
            if ((state_q == S_DONE || state_q == S_ERROR) && start) begin
                hcnt <= '0;
                comp <= '0;
                pcnt <= '0;
                col  <= '0;
                row  <= '0;
            end
        end
    end

    // Header fields shift in little-endian; colour MSBs held until the R byte
    always_ff @(posedge clk) begin
        if (acc && state_q == S_HEADER) begin
            case (hcnt)
                6'd0, 6'd1:                 sig    <= {in_data, sig[15:8]};
                6'd10, 6'd11, 6'd12, 6'd13: off    <= {in_data, off[31:8]};
                6'd18, 6'd19, 6'd20, 6'd21: w      <= {in_data, w[31:8]};
                6'd22, 6'd23, 6'd24, 6'd25: h      <= {in_data, h[31:8]};
                6'd26, 6'd27:               planes <= {in_data, planes[15:8]};
                6'd28, 6'd29:               bpp    <= {in_data, bpp[15:8]};
                default: ;
            endcase
        end
        if (acc && state_q == S_PIXEL) begin
            if (comp == 2'd0) b7 <= in_data[7];
            if (comp == 2'd1) g7 <= in_data[7];
        end
    end

endmodule

// File: tb/tb_bmp_plot_reader.sv
// Directed bench for bmp_plot_reader: file bytes queued per test, expected plots scoreboarded on acceptance.
module tb_bmp_plot_reader;

    logic       clk = 1'b0;
    logic       reset, start, in_valid, in_ready, plot, done, error;
    logic [7:0] in_data;
    logic [9:0] x;
    logic [8:0] y;
    logic [2:0] color;

    bmp_plot_reader #(.MAX_W(336), .MAX_H(210)) dut (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .x(x), .y(y), .color(color), .plot(plot), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  d;
        bit          has;
        logic [21:0] e;
    } ent_t;

    ent_t        fq[$];
    logic [21:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_plots = 0;
    bit          gaps = 0;
    int          p0, nacc;
    logic [7:0]  rb, gb, bb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (plot === 1'b1) begin
            n_plots++;
            chk("plot_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("plot_xyc", 32'({x, y, color}), 32'(exp_q.pop_front()));
        end
    end

    task automatic push_b(input logic [7:0] d);
        ent_t en;
        en.d = d; en.has = 0; en.e = '0;
        fq.push_back(en);
    endtask

    task automatic push32(input logic [31:0] v);
        for (int i = 0; i < 4; i++) push_b(v[8*i +: 8]);
    endtask

    task automatic hdr(input int w, input int h, input logic [7:0] s1, input logic [7:0] bpp);
        int rowb;
        rowb = (w * 3 + 3) / 4 * 4;
        push_b(8'h42); push_b(s1);
        push32(32'(54 + rowb * h)); push32(0); push32(54); push32(40);
        push32(32'(w)); push32(32'(h));
        push_b(8'd1); push_b(8'd0); push_b(bpp); push_b(8'd0);
        repeat (24) push_b(8'd0);
    endtask

    task automatic px(input logic [7:0] b, input logic [7:0] g, input logic [7:0] r,
                      input int px_x, input int px_y, input logic [2:0] c);
        ent_t en;
        push_b(b); push_b(g);
        en.d = r; en.has = 1; en.e = {10'(px_x), 9'(px_y), c};
        fq.push_back(en);
    endtask

    task automatic pads(input int w);
        repeat ((4 - (3 * w) % 4) % 4) push_b(8'hAA);
    endtask

    task automatic send_byte();
        ent_t en;
        int k;
        en = fq.pop_front();
        @(negedge clk);
        if (gaps && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = en.d;
        k = 0;
        while (in_ready !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (in_ready !== 1'b1) begin
            chk("in_ready_timeout", 32'(in_ready), 32'd1);
            return;
        end
        @(posedge clk);
`ifdef BMP_PLOT_TRANSPARENT_EN
        if (en.has && en.e[2:0] != 3'b000) exp_q.push_back(en.e);
`else
        if (en.has) exp_q.push_back(en.e);
`endif
    endtask

    task automatic send_all();
        while (fq.size() > 0) send_byte();
    endtask

    task automatic settle();
        @(negedge clk);
        in_valid = 1'b0;
        #1;
    endtask

    task automatic end_ok(input string tag);
        settle();
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_ready_low"}, 32'(in_ready), 32'd0);
        chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic end_err(input string tag);
        settle();
        chk({tag, "_error"}, 32'(error), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_ready_low"}, 32'(in_ready), 32'd0);
        nacc = 0;
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (4) begin
            @(negedge clk);
            if (in_ready) nacc++;
        end
        in_valid = 1'b0;
        chk({tag, "_blocked"}, 32'(nacc), 32'd0);
    endtask

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        #1;
        chk("start_ready", 32'(in_ready), 32'd1);
        chk("start_flags", 32'({done, error}), 32'd0);
    endtask

    task automatic file_2x2();
        hdr(2, 2, 8'h4D, 8'd24);
        px(8'hFF, 8'hFF, 8'hFF, 0, 1, 3'd7); px(8'h00, 8'h00, 8'hFF, 1, 1, 3'd4); pads(2);
        px(8'h00, 8'hFF, 8'h00, 0, 0, 3'd2); px(8'hFF, 8'h00, 8'h00, 1, 0, 3'd1); pads(2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog n_plots=%0d required=finish", n_plots);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({in_ready, plot, x, y, color, done, error}), 32'd0);
        reset = 1'b0;
        @(negedge clk); #1;
        chk("ready_after_reset", 32'(in_ready), 32'd1);

        // 2x2 with two pad bytes per row
        p0 = n_plots;
        file_2x2();
        send_all();
        end_ok("img2x2");
        chk("img2x2_plots", 32'(n_plots - p0), 32'd4);
        do_start();

        // Full-width single row, no padding, random valid gaps
        gaps = 1; p0 = n_plots;
        hdr(336, 1, 8'h4D, 8'd24);
        for (int i = 0; i < 336; i++) px(8'hFF, 8'hFF, 8'hFF, i, 0, 3'd7);
        send_all();
        settle();
        chk("wide_plot_with_done", 32'({plot, done}), 32'd3);
        chk("wide_last_xy", 32'({x, y}), 32'({10'd335, 9'd0}));
        chk("wide_drained", 32'(exp_q.size()), 32'd0);
        chk("wide_plots", 32'(n_plots - p0), 32'd336);
        do_start();

        // 16x4 random colours
        p0 = n_plots;
        hdr(16, 4, 8'h4D, 8'd24);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 16; c++) begin
                bb = 8'($urandom); gb = 8'($urandom); rb = 8'($urandom);
                px(bb, gb, rb, c, 3 - r, {rb[7], gb[7], bb[7]});
            end
        send_all();
        end_ok("rand16x4");
        do_start();

        // Full-height single column, one pad byte per row
        hdr(1, 210, 8'h4D, 8'd24);
        for (int r = 0; r < 210; r++) begin
            px(8'h80, 8'h00, 8'h80, 0, 209 - r, 3'd5);
            pads(1);
        end
        send_all();
        end_ok("tall1x210");
        do_start();
        gaps = 0;

        // Black pixels; transparency drops their plots
        p0 = n_plots;
        hdr(3, 1, 8'h4D, 8'd24);
        px(8'h00, 8'h00, 8'h00, 0, 0, 3'd0); px(8'hFF, 8'hFF, 8'hFF, 1, 0, 3'd7);
        px(8'h00, 8'h00, 8'h00, 2, 0, 3'd0); pads(3);
        send_all();
        end_ok("img3x1");
`ifdef BMP_PLOT_TRANSPARENT_EN
        chk("img3x1_plots", 32'(n_plots - p0), 32'd1);
`else
        chk("img3x1_plots", 32'(n_plots - p0), 32'd3);
`endif
        do_start();

        // Header rejections
        p0 = n_plots;
        hdr(2, 2, 8'h4D, 8'd32);
        send_all();
        end_err("bpp32");
        do_start();
        hdr(337, 1, 8'h4D, 8'd24);
        send_all();
        end_err("width337");
        do_start();
        hdr(1, 1, 8'h4D, 8'd24);
        px(8'hFF, 8'hFF, 8'hFF, 0, 0, 3'd7); pads(1);
        send_all();
        end_ok("img1x1");
        hdr(2, 2, 8'h4E, 8'd24);
        do_start();
        send_all();
        end_err("sigBN");
        chk("reject_plots", 32'(n_plots - p0), 32'd1);
        do_start();

        // Reset after the third pixel of a 4x1 image
        hdr(4, 1, 8'h4D, 8'd24);
        for (int i = 0; i < 3; i++) px(8'h00, 8'hFF, 8'hFF, i, 0, 3'd6);
        send_all();
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk); #1;
        chk("abort_outputs", 32'({plot, x, y, color, done, error}), 32'd0);
        chk("abort_ready", 32'(in_ready), 32'd1);
        chk("abort_drained", 32'(exp_q.size()), 32'd0);
        p0 = n_plots;
        file_2x2();
        send_all();
        end_ok("after_abort");
        chk("after_abort_plots", 32'(n_plots - p0), 32'd4);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
